// File: rtl/pmips_dmem_io.sv
// PMIPS data-memory responder: word RAM plus memory-mapped output latch, synchronised
// input port and a prescaled timer with compare flag and interrupt.
module pmips_dmem_io #(
   parameter int DEPTH    = 128,
   parameter int PRESCALE = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] dmemaddr,
   input  logic [15:0] dmemwdata,
   input  logic        dmemwrite,
   input  logic        dmemread,
   output logic [15:0] dmemrdata,
   input  logic [7:0]  io_in,
   output logic [7:0]  io_out,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

   localparam logic [15:0] A_OUT  = 16'hFFF0;
   localparam logic [15:0] A_IN   = 16'hFFF2;
   localparam logic [15:0] A_TCNT = 16'hFFF4;
   localparam logic [15:0] A_TCMP = 16'hFFF6;
   localparam logic [15:0] A_STAT = 16'hFFF8;

   typedef struct packed {
      logic ram;
      logic out;
      logic inp;
      logic tcnt;
      logic tcmp;
      logic stat;
   } sel_t;

   sel_t        sel;
   logic [15:0] word_addr;
   logic [15:0] mem [DEPTH];
   logic [15:0] ram_rd;

   logic [7:0]    sync1, sync2;
   logic [15:0]   tcnt, tcmp;
   logic [PW-1:0] psc;
   logic          flag, ten, ien;
   logic          tick, match, flag_set, flag_clr;
   logic          unused_bit0;

   assign unused_bit0 = dmemaddr[0];
   assign word_addr   = {dmemaddr[15:1], 1'b0};

   // Anything above the RAM window that is not one of the five registers decodes to nothing.
   always_comb begin
      sel      = '0;
      sel.ram  = (dmemaddr[15:AW+1] == '0);
      sel.out  = (word_addr == A_OUT);
      sel.inp  = (word_addr == A_IN);
      sel.tcnt = (word_addr == A_TCNT);
      sel.tcmp = (word_addr == A_TCMP);
      sel.stat = (word_addr == A_STAT);
   end

   assign ram_rd = mem[dmemaddr[AW:1]];

   always_comb begin
      dmemrdata = 16'h0000;
      if (dmemread) begin
         if (sel.ram)       dmemrdata = ram_rd;
         else if (sel.out)  dmemrdata = {8'h00, io_out};
         else if (sel.inp)  dmemrdata = {8'h00, sync2};
         else if (sel.tcnt) dmemrdata = tcnt;
         else if (sel.tcmp) dmemrdata = tcmp;
         else if (sel.stat) dmemrdata = {13'h0000, ien, ten, flag};
      end
   end

   // RAM has no reset, so a write presented during reset still lands.
   always_ff @(posedge clock) begin
      if (dmemwrite && sel.ram) mem[dmemaddr[AW:1]] <= dmemwdata;
   end

   assign tick     = ten && (psc == PSC_LAST);
   assign match    = (tcnt == tcmp);
   assign flag_set = tick && match;
   assign flag_clr = dmemwrite && sel.stat && dmemwdata[0];

   always_ff @(posedge clock) begin
      if (reset) begin
         io_out <= 8'h00;
         sync1  <= 8'h00;
         sync2  <= 8'h00;
         tcnt   <= 16'h0000;
         tcmp   <= 16'h0000;
         psc    <= '0;
         flag   <= 1'b0;
         ten    <= 1'b0;
         ien    <= 1'b0;
      end else begin
         sync1 <= io_in;
         sync2 <= sync1;
         if (ten) psc <= tick ? '0 : psc + PW'(1);
         if (tick) tcnt <= match ? 16'h0000 : tcnt + 16'h0001;
         // CPU write follows the tick update so it overrides the increment.
         if (dmemwrite && sel.tcnt) tcnt <= dmemwdata;
         if (dmemwrite && sel.tcmp) tcmp <= dmemwdata;
         if (dmemwrite && sel.out)  io_out <= dmemwdata[7:0];
         if (dmemwrite && sel.stat) begin
            ten <= dmemwdata[1];
            ien <= dmemwdata[2];
         end
         flag <= flag_set | (flag & ~flag_clr);
      end
   end

   assign irq = flag & ien;

endmodule
